// File: rtl/adaptive_threshold_pkg.sv
// rtl/adaptive_threshold_pkg.sv - shared widths, result levels and scan states for adaptive thresholding
package adaptive_threshold_pkg;

  localparam int DEFAULT_WIDTH_BITS  = 8;
  localparam int DEFAULT_HEIGHT_BITS = 8;
  localparam int PIXEL_BITS          = 8;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  localparam pixel_t DEFAULT_HIGH_VALUE = 8'd255;
  localparam pixel_t DEFAULT_LOW_VALUE  = 8'd0;

  localparam logic [1:0] SCAN  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/adaptive_threshold_if.sv
// rtl/adaptive_threshold_if.sv - ROM read and result write bus of the binarisation core
interface adaptive_threshold_if
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS  = DEFAULT_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEFAULT_HEIGHT_BITS
);
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  pixel_t                 iImageData;
  logic [WIDTH_BITS-1:0]  oThresholdCol;
  logic [HEIGHT_BITS-1:0] oThresholdRow;
  pixel_t                 iThresholdData;
  logic [WIDTH_BITS-1:0]  oResultCol;
  logic [HEIGHT_BITS-1:0] oResultRow;
  pixel_t                 oResultData;
  logic                   oResultWren;
  logic                   finished;

  modport master (
    output oImageCol, oImageRow, oThresholdCol, oThresholdRow,
    output oResultCol, oResultRow, oResultData, oResultWren, finished,
    input  iImageData, iThresholdData
  );

  modport slave (
    input  oImageCol, oImageRow, oThresholdCol, oThresholdRow,
    input  oResultCol, oResultRow, oResultData, oResultWren, finished,
    output iImageData, iThresholdData
  );
endinterface

// File: rtl/adaptive_threshold_raster_counter.sv
// rtl/adaptive_threshold_raster_counter.sv - column-fastest raster address counter that holds at the last pixel
module adaptive_threshold_raster_counter #(
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                advance,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                atLast
);

  assign atLast = (&col) && (&row);

  // Once the final coordinate is reached the counter parks there instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (advance && !atLast) begin
      if (&col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adaptive_threshold.sv
// rtl/adaptive_threshold.sv - raster-scans image and threshold ROMs and writes a binarised result per pixel
module adaptive_threshold
  import adaptive_threshold_pkg::*;
#(
  parameter int     WIDTH_BITS  = DEFAULT_WIDTH_BITS,
  parameter int     HEIGHT_BITS = DEFAULT_HEIGHT_BITS,
  parameter pixel_t HIGH_VALUE  = DEFAULT_HIGH_VALUE,
  parameter pixel_t LOW_VALUE   = DEFAULT_LOW_VALUE
) (
  input  logic                 clock,
  input  logic                 reset,
  adaptive_threshold_if.master bus
);

  logic [1:0]             state;
  logic [WIDTH_BITS-1:0]  scanCol;
  logic [HEIGHT_BITS-1:0] scanRow;
  logic                   scanAtLast;

  logic                   stage1Valid;
  logic [WIDTH_BITS-1:0]  stage1Col;
  logic [HEIGHT_BITS-1:0] stage1Row;

  logic [WIDTH_BITS-1:0]  resultCol;
  logic [HEIGHT_BITS-1:0] resultRow;
  pixel_t                 resultData;
  logic                   resultWren;
  logic                   doneFlag;

  adaptive_threshold_raster_counter #(
    .COL_BITS (WIDTH_BITS),
    .ROW_BITS (HEIGHT_BITS)
  ) scanCounter (
    .clock   (clock),
    .reset   (reset),
    .advance (state == SCAN),
    .col     (scanCol),
    .row     (scanRow),
    .atLast  (scanAtLast)
  );

  // Stage 1 lines the coordinate up with the ROM data that arrives one cycle later;
  // stage 2 compares and issues the write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      stage1Valid <= 1'b0;
      stage1Col   <= '0;
      stage1Row   <= '0;
      resultCol   <= '0;
      resultRow   <= '0;
      resultData  <= '0;
      resultWren  <= 1'b0;
      doneFlag    <= 1'b0;
    end else begin
      stage1Valid <= (state == SCAN);
      stage1Col   <= scanCol;
      stage1Row   <= scanRow;
      resultWren  <= stage1Valid;
      if (stage1Valid) begin
        resultCol  <= stage1Col;
        resultRow  <= stage1Row;
        resultData <= (bus.iImageData > bus.iThresholdData) ? HIGH_VALUE : LOW_VALUE;
      end

      case (state)
        SCAN: begin
          if (scanAtLast) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last write is on the bus once stage 1 has emptied behind it.
          if (!stage1Valid && resultWren) begin
            state    <= DONE;
            doneFlag <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

  assign bus.oImageCol     = scanCol;
  assign bus.oImageRow     = scanRow;
  assign bus.oThresholdCol = scanCol;
  assign bus.oThresholdRow = scanRow;
  assign bus.oResultCol    = resultCol;
  assign bus.oResultRow    = resultRow;
  assign bus.oResultData   = resultData;
  assign bus.oResultWren   = resultWren;
  assign bus.finished      = doneFlag;

endmodule

// File: tb/tb_adaptive_threshold.sv
// tb/tb_adaptive_threshold.sv - scoreboard bench for the adaptive threshold binarisation core
module tb_adaptive_threshold;

  localparam int WB = 8;
  localparam int HB = 3;
  localparam int NPIX = 1 << (WB + HB);
  localparam int MAX_ADDR = NPIX - 1;

  logic clock;
  logic reset;
  int   mode;
  int   edgesSinceRelease;
  int   testsRun;
  int   testsFailed;

  logic [31:0] expQ[$];
  logic [31:0] addrHist[$];

  adaptive_threshold_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus ();

  adaptive_threshold #(
    .WIDTH_BITS  (WB),
    .HEIGHT_BITS (HB),
    .HIGH_VALUE  (8'd255),
    .LOW_VALUE   (8'd0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] imgFn(int m, int r, int c);
    case (m)
      0:       imgFn = 8'd100;
      1:       imgFn = 8'd128;
      2:       imgFn = 8'(c);
      default: imgFn = 8'(c * 7 + r * 13);
    endcase
  endfunction

  function automatic logic [7:0] thrFn(int m, int r, int c);
    case (m)
      0:       thrFn = 8'd50;
      1:       thrFn = 8'd128;
      2:       thrFn = 8'd127;
      default: thrFn = 8'(c * 5 + r * 29 + 90);
    endcase
  endfunction

  // Synchronous ROM models with one cycle of read latency.
  always @(posedge clock) begin
    bus.iImageData     <= imgFn(mode, int'(bus.oImageRow), int'(bus.oImageCol));
    bus.iThresholdData <= thrFn(mode, int'(bus.oThresholdRow), int'(bus.oThresholdCol));
  end

  always @(posedge clock or posedge reset) begin
    if (reset) edgesSinceRelease <= 0;
    else       edgesSinceRelease <= edgesSinceRelease + 1;
  end

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, edgesSinceRelease);
    end
  endtask

  function automatic logic [31:0] outputsWord();
    outputsWord = 32'({bus.oImageRow, bus.oImageCol, bus.oResultRow, bus.oResultCol,
                       bus.oResultData, bus.oResultWren, bus.finished});
  endfunction

  task automatic startScan(input int m);
    logic [7:0] d;
    reset = 1'b1;
    mode  = m;
    expQ.delete();
    addrHist.delete();
    for (int n = 0; n < NPIX; n++) begin
      d = (imgFn(m, n >> WB, n % (1 << WB)) > thrFn(m, n >> WB, n % (1 << WB))) ? 8'd255 : 8'd0;
      expQ.push_back(32'(((n >> WB) << (WB + 8)) | ((n % (1 << WB)) << 8) | int'(d)));
    end
    repeat (3) @(negedge clock);
    checkEq("resetState", outputsWord(), 32'd0);
    reset = 1'b0;
  endtask

  task automatic runScan(input string name);
    int writes   = 0;
    int firstWr  = -1;
    int lastWr   = -1;
    int finAt    = -1;
    #1;
    for (int c = 0; c < NPIX + 40 && finAt < 0; c++) begin
      checkEq({name, ".thrAddr"}, 32'({bus.oThresholdRow, bus.oThresholdCol}),
              32'({bus.oImageRow, bus.oImageCol}));
      addrHist.push_back(32'({bus.oImageRow, bus.oImageCol}));
      if (bus.oResultWren) begin
        if (expQ.size() == 0) begin
          checkEq({name, ".extraWrite"}, 32'(writes), 32'(NPIX - 1));
        end else begin
          checkEq({name, ".write"}, 32'({bus.oResultRow, bus.oResultCol, bus.oResultData}),
                  expQ.pop_front());
        end
        if (addrHist.size() >= 3)
          checkEq({name, ".align"}, 32'({bus.oResultRow, bus.oResultCol}),
                  addrHist[addrHist.size() - 3]);
        else
          checkEq({name, ".alignEarly"}, 32'(addrHist.size()), 32'd3);
        if (firstWr < 0) firstWr = edgesSinceRelease;
        lastWr = edgesSinceRelease;
        writes++;
      end
      if (bus.finished) finAt = edgesSinceRelease;
      else @(negedge clock);
    end
    checkEq({name, ".firstWrite"}, 32'(firstWr), 32'd2);
    checkEq({name, ".lastWrite"}, 32'(lastWr), 32'(NPIX + 1));
    checkEq({name, ".writes"}, 32'(writes), 32'(NPIX));
    checkEq({name, ".finishedAt"}, 32'(finAt), 32'(NPIX + 2));
    checkEq({name, ".queueEmpty"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    mode        = 0;
    bus.iImageData     = 8'd0;
    bus.iThresholdData = 8'd0;

    startScan(0);
    runScan("above");

    startScan(1);
    runScan("equal");

    startScan(2);
    runScan("colRamp");

    // Abort a scan part-way and make sure it restarts cleanly from (0,0).
    startScan(3);
    while (edgesSinceRelease < 1000) @(negedge clock);
    reset = 1'b1;
    #1;
    checkEq("asyncReset", outputsWord(), 32'd0);
    startScan(3);
    runScan("rescan");

    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checkEq("holdWren", 32'(bus.oResultWren), 32'd0);
      checkEq("holdFinished", 32'(bus.finished), 32'd1);
      checkEq("holdAddr", 32'({bus.oImageRow, bus.oImageCol}), 32'(MAX_ADDR));
      checkEq("holdResAddr", 32'({bus.oResultRow, bus.oResultCol}), 32'(MAX_ADDR));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/adaptive_threshold.md
Name: adaptive_threshold

Overview:
- Pixel-wise binarisation core of the adaptive-thresholding pipeline.
- Scans a WIDTH x HEIGHT 8-bit greyscale image in raster order and reads the image pixel and the precomputed local threshold (box-filter output) at the same coordinate.
- Writes 255 (pixel > threshold) or 0 (otherwise) to a result memory.
- Sits between the image/threshold ROM readers (synchronous, 1-cycle read latency) and the result RAM; flags completion on `finished`.

Parameters:
- WIDTH_BITS, 8, column address width; image width = 2**WIDTH_BITS.
- HEIGHT_BITS, 8, row address width; image height = 2**HEIGHT_BITS.
- HIGH_VALUE, 8'd255, result value when pixel > threshold.
- LOW_VALUE, 8'd0, result value otherwise.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- oImageCol  out  WIDTH_BITS  image ROM column address.
- oImageRow  out  HEIGHT_BITS  image ROM row address.
- iImageData  in  8  image pixel; valid 1 cycle after the address.
- oThresholdCol  out  WIDTH_BITS  threshold ROM column address (always equals oImageCol).
- oThresholdRow  out  HEIGHT_BITS  threshold ROM row address (always equals oImageRow).
- iThresholdData  in  8  threshold value; valid 1 cycle after the address.
- oResultCol  out  WIDTH_BITS  result write column.
- oResultRow  out  HEIGHT_BITS  result write row.
- oResultData  out  8  HIGH_VALUE or LOW_VALUE.
- oResultWren  out  1  result write strobe, one cycle per pixel.
- finished  out  1  sticky done flag.

Behaviour:
- Reset (async, while high):
  - All address, result and data outputs are 0; oResultWren = 0; finished = 0.
  - State = SCAN; read counter = (col 0, row 0).
  - Asserting reset mid-scan aborts the scan, and the scan restarts from (0,0) after release.
- Cycle 0 = first rising edge with reset low. All outputs are registered.
- States:
  - SCAN: read addresses advance every cycle.
  - DRAIN: addresses frozen, pipeline emptying.
  - DONE: idle.
- Read counter:
  - Column fastest. Pixel n is addressed during cycle n with col = n mod 2**WIDTH_BITS, row = n div 2**WIDTH_BITS.
  - Column wraps from max to 0 and row increments.
  - At (max col, max row) the counter does not wrap: it holds that value and the state goes SCAN -> DRAIN.
- Pipeline (throughput 1 pixel/clock):
  - Stage 1 registers the address and a valid bit, aligning them with the ROM data that returns in cycle n+1.
  - Stage 2, on the edge ending cycle n+1: result = (iImageData > iThresholdData) ? HIGH_VALUE : LOW_VALUE, as an unsigned 8-bit compare.
  - Stage 2 registers oResultCol/oResultRow = pixel n coordinate and oResultWren = 1.
  - Net result: pixel n is written during cycle n+2 (2-cycle latency from address).
  - Equality yields LOW_VALUE.
- Write strobe:
  - oResultWren is high for exactly 2**(WIDTH_BITS+HEIGHT_BITS) cycles, contiguous, with no gaps and no duplicate coordinates.
  - When oResultWren is low, oResultCol/Row/Data hold their last values.
- Completion:
  - DRAIN -> DONE once the last write has been issued.
  - finished rises on the same edge oResultWren falls after the last pixel: cycle N+2, with N = total pixels. For 256x256 that is cycle 65538.
  - finished stays 1 until reset. There is no automatic restart.
- Boundaries:
  - First pixel (0,0) is written in cycle 2.
  - Last pixel (255,255) is written in cycle 65537.
  - Row changes exactly when col wraps 255 -> 0.

Decomposition:
- Shared package holds WIDTH_BITS and HEIGHT_BITS defaults, PIXEL_BITS = 8, HIGH_VALUE/LOW_VALUE, and the state encoding (SCAN, DRAIN, DONE).
- One natural sub-module: raster_counter. It provides col/row registers, end-of-frame detect and hold-at-last, and is also reusable by the box filter.
- ROM readers (image, threshold) stay external. Each is a synchronous 1-cycle-latency lookup addressed by {row, col}.

Test Plan:
- Image ROM all 100, threshold ROM all 50 -> 65536 writes, all data 255; first write cycle 2 at (0,0); finished at cycle 65538.
- Image = threshold = 128 everywhere -> all writes 0 (equality yields LOW).
- Image pixel = col, threshold = 127 -> cols 0..127 write 0, cols 128..255 write 255 on every row; coordinates strictly raster-ordered with no gaps.
- Check address/write alignment: the oResultCol/Row sequence equals the oImageCol/Row sequence delayed by 2 cycles; oThresholdCol/Row always equal oImageCol/Row.
- Assert reset at pixel ~1000, release 3 cycles later -> outputs go 0 immediately (async); rescan starts at (0,0); exactly 65536 writes after release; finished low until the end.
- After finished: hold 100 extra cycles -> oResultWren stays 0, finished stays 1, addresses hold (255,255).
